// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: operand read with multi-source forwarding, load-use stall,
// jump/branch resolution with wrong-path flush, and EBREAK halt.
module rv32i_decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_FWD      = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_IW       = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             iw_in,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [XLEN-1:0]         rs1_data_in,
  input  logic [XLEN-1:0]         rs2_data_in,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [5*NUM_FWD-1:0]    fwd_reg,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_load,
  input  logic [4:0]              ex_rd,
  output logic [4:0]              rs1_reg,
  output logic [4:0]              rs2_reg,
  output logic                    stall_out,
  output logic                    jump_en_out,
  output logic [XLEN-1:0]         jump_addr_out,
  output logic [31:0]             iw_out,
  output logic [XLEN-1:0]         pc_out,
  output logic [XLEN-1:0]         rs1_data_out,
  output logic [XLEN-1:0]         rs2_data_out,
  output logic [4:0]              wb_reg_out,
  output logic                    wb_en_out,
  output logic                    halted_out
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1, op2, imm_i, imm_b, imm_j, jalr_sum;
  logic            use_rs1, use_rs2, taken, pass, wb_en;

  assign opcode  = iw_in[6:0];
  assign funct3  = iw_in[14:12];
  assign rs1_reg = iw_in[19:15];
  assign rs2_reg = iw_in[24:20];

  assign imm_i = {{(XLEN-12){iw_in[31]}}, iw_in[31:20]};
  assign imm_b = {{(XLEN-13){iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21],
                  1'b0};

  // Walk oldest to youngest so the youngest matching source overrides.
  always_comb begin
    op1 = rs1_data_in;
    op2 = rs2_data_in;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs1_reg) op1 = fwd_data[XLEN*i +: XLEN];
      if (fwd_en[i] && fwd_reg[5*i +: 5] == rs2_reg) op2 = fwd_data[XLEN*i +: XLEN];
    end
    if (rs1_reg == 5'd0) op1 = '0;
    if (rs2_reg == 5'd0) op2 = '0;
  end

  assign use_rs1 = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
  assign use_rs2 = (opcode == OpBranch || opcode == OpStore || opcode == OpOp);
  assign jalr_sum = op1 + imm_i;

  assign stall_out = (state_q == StRun) && ex_load && (ex_rd != 5'd0) &&
                     ((use_rs1 && ex_rd == rs1_reg) || (use_rs2 && ex_rd == rs2_reg));

  always_comb begin
    taken         = 1'b0;
    jump_addr_out = pc_in;
    unique case (opcode)
      OpJal: begin
        taken         = 1'b1;
        jump_addr_out = pc_in + imm_j;
      end
      OpJalr: begin
        taken         = 1'b1;
        jump_addr_out = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OpBranch: begin
        unique case (funct3)
          3'b000:  taken = (op1 == op2);
          3'b001:  taken = (op1 != op2);
          3'b100:  taken = ($signed(op1) < $signed(op2));
          3'b101:  taken = ($signed(op1) >= $signed(op2));
          3'b110:  taken = (op1 < op2);
          3'b111:  taken = (op1 >= op2);
          default: taken = 1'b0;
        endcase
        jump_addr_out = pc_in + imm_b;
      end
      default: ;
    endcase
    jump_en_out = taken && (state_q == StRun) && !stall_out;
    if (!jump_en_out) jump_addr_out = pc_in;
  end

  assign pass  = (state_q == StRun) && !stall_out;
  assign wb_en = !(opcode == OpStore || opcode == OpBranch || opcode == OpJal ||
                   opcode == OpJalr || opcode == OpFence || opcode == OpSystem) &&
                 (iw_in[11:7] != 5'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (pass && iw_in == 32'h00100073) begin
          state_d = StHalt;
        end else if (jump_en_out) begin
          state_d = StFlush;
          cnt_d   = 3'(FLUSH_CYCLES);
        end
      end
      StFlush: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StRun;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      cnt_q        <= 3'd0;
      iw_out       <= NOP_IW;
      pc_out       <= '0;
      rs1_data_out <= '0;
      rs2_data_out <= '0;
      wb_reg_out   <= 5'd0;
      wb_en_out    <= 1'b0;
      halted_out   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_out     <= pc_in;
      halted_out <= (state_d == StHalt);
      if (pass) begin
        iw_out       <= iw_in;
        rs1_data_out <= op1;
        rs2_data_out <= op2;
        wb_reg_out   <= iw_in[11:7];
        wb_en_out    <= wb_en;
      end else begin
        iw_out       <= NOP_IW;
        rs1_data_out <= '0;
        rs2_data_out <= '0;
        wb_reg_out   <= 5'd0;
        wb_en_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed scenarios plus random instruction streams,
// all compared against a behavioural model of the decode rules.
module tb_rv32i_decode_stage;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam int          FLUSHN = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iw_in, pc_in, rs1_data_in, rs2_data_in;
  logic [2:0]  fwd_en;
  logic [14:0] fwd_reg;
  logic [95:0] fwd_data;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic [4:0]  rs1_reg, rs2_reg;
  logic        stall_out, jump_en_out;
  logic [31:0] jump_addr_out, iw_out, pc_out, rs1_data_out, rs2_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out, halted_out;

  rv32i_decode_stage dut (
    .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .ex_load(ex_load), .ex_rd(ex_rd), .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
    .stall_out(stall_out), .jump_en_out(jump_en_out), .jump_addr_out(jump_addr_out),
    .iw_out(iw_out), .pc_out(pc_out), .rs1_data_out(rs1_data_out),
    .rs2_data_out(rs2_data_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
    .halted_out(halted_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Model state: 0 = running, 1 = flushing, 2 = halted.
  int  m_mode  = 0;
  int  m_cnt   = 0;
  bit  m_known = 0;
  int  halt_run = 0;

  function automatic logic [31:0] m_operand(input logic [4:0] rs, input logic [31:0] rf,
                                            input logic [2:0] fen, input logic [14:0] freg,
                                            input logic [95:0] fdata);
    if (rs == 0) return 32'd0;
    for (int i = 0; i < 3; i++)
      if (fen[i] && freg[5*i +: 5] == rs) return fdata[32*i +: 32];
    return rf;
  endfunction

  task automatic step(input logic [31:0] iw, input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [2:0] fen, input logic [14:0] freg,
                      input logic [95:0] fdata, input logic exl, input logic [4:0] exrd,
                      input logic rst);
    logic [6:0] op;
    logic [4:0] s1, s2, rd;
    logic [31:0] a, b, target, jaddr;
    logic signed [12:0] ib;
    logic signed [20:0] ij;
    logic signed [11:0] ii;
    int ibx, ijx, iix;
    bit use1, use2, stall, taken, jen, pass, wben;
    int nmode, ncnt;
    iw_in = iw; pc_in = pc; rs1_data_in = r1; rs2_data_in = r2;
    fwd_en = fen; fwd_reg = freg; fwd_data = fdata; ex_load = exl; ex_rd = exrd; reset = rst;
    @(negedge clk);
    #1;
    op = iw[6:0]; s1 = iw[19:15]; s2 = iw[24:20]; rd = iw[11:7];
    a = m_operand(s1, r1, fen, freg, fdata);
    b = m_operand(s2, r2, fen, freg, fdata);
    ib = {iw[31], iw[7], iw[30:25], iw[11:8], 1'b0}; ibx = ib;
    ij = {iw[31], iw[19:12], iw[20], iw[30:21], 1'b0}; ijx = ij;
    ii = iw[31:20]; iix = ii;
    use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    use2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
    stall = exl && exrd != 0 && ((use1 && exrd == s1) || (use2 && exrd == s2)) && m_mode == 0;
    taken = 0; target = pc;
    if (op == 7'b1101111) begin taken = 1; target = pc + ijx; end
    else if (op == 7'b1100111) begin taken = 1; target = (a + iix) & 32'hFFFF_FFFE; end
    else if (op == 7'b1100011) begin
      target = pc + ibx;
      case (iw[14:12])
        3'd0: taken = a == b;
        3'd1: taken = a != b;
        3'd4: taken = $signed(a) < $signed(b);
        3'd5: taken = $signed(a) >= $signed(b);
        3'd6: taken = a < b;
        3'd7: taken = a >= b;
        default: taken = 0;
      endcase
    end
    jen = m_mode == 0 && !stall && taken;
    jaddr = jen ? target : pc;
    check("rs1_reg", 32'(rs1_reg), 32'(s1));
    check("rs2_reg", 32'(rs2_reg), 32'(s2));
    if (m_known) begin
      check("stall_out", 32'(stall_out), 32'(stall));
      check("jump_en_out", 32'(jump_en_out), 32'(jen));
      check("jump_addr_out", jump_addr_out, jaddr);
    end
    pass = 0; nmode = m_mode; ncnt = m_cnt;
    if (rst) begin nmode = 0; ncnt = 0; end
    else if (m_mode == 2) nmode = 2;
    else if (m_mode == 1) begin ncnt = m_cnt - 1; if (m_cnt == 1) nmode = 0; end
    else if (!stall) begin
      pass = 1;
      if (iw == EBREAK) nmode = 2;
      else if (jen) begin nmode = 1; ncnt = FLUSHN; end
    end
    wben = !(op inside {7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111,
                        7'b1110011}) && rd != 0;
    @(posedge clk);
    #1;
    check("iw_out", iw_out, rst ? NOP : (pass ? iw : NOP));
    check("pc_out", pc_out, rst ? 32'd0 : pc);
    check("wb_en_out", 32'(wb_en_out), 32'(pass && !rst && wben));
    check("halted_out", 32'(halted_out), 32'(!rst && nmode == 2));
    if (rst) begin
      check("rs1_data_out rst", rs1_data_out, 32'd0);
      check("wb_reg_out rst", 32'(wb_reg_out), 32'd0);
    end else if (pass) begin
      check("rs1_data_out", rs1_data_out, a);
      check("rs2_data_out", rs2_data_out, b);
      check("wb_reg_out", 32'(wb_reg_out), 32'(rd));
    end
    m_mode = nmode; m_cnt = ncnt;
    if (rst) m_known = 1;
  endtask

  function automatic logic [31:0] rand_iw();
    logic [31:0] w;
    logic [6:0]  ops [9];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    if ($urandom_range(0, 49) == 0) return EBREAK;
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  localparam logic [31:0] ADD_X1_X5_X0 = {7'd0, 5'd0, 5'd5, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] ADD_X1_X0_X0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] ADD_X1_X0_X5 = {7'd0, 5'd5, 5'd0, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] LUI_X5       = {20'h12345, 5'd5, 7'b0110111};
  localparam logic [31:0] BEQ_16       = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0,
                                          7'b1100011};
  localparam logic [31:0] JALR_4       = {12'd4, 5'd3, 3'd0, 5'd1, 7'b1100111};
  localparam logic [31:0] BLTU_8       = {1'b0, 6'd0, 5'd2, 5'd1, 3'b110, 4'b0100, 1'b0,
                                          7'b1100011};
  localparam logic [31:0] BLT_8        = {1'b0, 6'd0, 5'd2, 5'd1, 3'b100, 4'b0100, 1'b0,
                                          7'b1100011};
  localparam logic [95:0] FD = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [14:0] F5 = {5'd5, 5'd5, 5'd5};

  initial begin
    step(NOP, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(NOP, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1);
    // Forwarding priority and x0.
    step(ADD_X1_X5_X0, 32'h10, 32'h1111, 0, 3'b011, F5, FD, 0, 0, 0);
    step(ADD_X1_X0_X0, 32'h14, 32'h1111, 0, 3'b011, {5'd0, 5'd0, 5'd0}, FD, 0, 0, 0);
    // Load-use stall on rs2, none for LUI.
    step(ADD_X1_X0_X5, 32'h18, 0, 0, 0, 0, 0, 1, 5, 0);
    step(LUI_X5, 32'h1C, 0, 0, 0, 0, 0, 1, 5, 0);
    // Taken BEQ, then a flush slot.
    step(BEQ_16, 32'h100, 7, 7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < FLUSHN + 1; i++) step(NOP, 32'h110 + 4 * i, 0, 0, 0, 0, 0, 0, 0, 0);
    // JALR target with LSB cleared, unsigned vs signed compare.
    step(JALR_4, 32'h200, 32'h203, 0, 0, 0, 0, 0, 0, 0);
    step(NOP, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0);
    step(BLTU_8, 32'h300, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
    step(BLT_8, 32'h304, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
    step(NOP, 32'h30C, 0, 0, 0, 0, 0, 0, 0, 0);
    // Branch held by a stall, then taken; a branch in the flush slot is ignored.
    step(BEQ_16, 32'h400, 3, 3, 0, 0, 0, 1, 1, 0);
    step(BEQ_16, 32'h400, 3, 3, 0, 0, 0, 0, 0, 0);
    step(BEQ_16, 32'h410, 3, 3, 0, 0, 0, 0, 0, 0);
    step(NOP, 32'h414, 0, 0, 0, 0, 0, 0, 0, 0);
    // EBREAK halts until reset.
    step(EBREAK, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(ADD_X1_X5_X0, 32'h504 + 4 * i, 1, 2, 0, 0, 0, 0, 0, 0);
    step(ADD_X1_X5_X0, 32'h510, 1, 2, 0, 0, 0, 0, 0, 1);
    step(ADD_X1_X5_X0, 32'h514, 1, 2, 0, 0, 0, 0, 0, 0);
    // Random streams.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r1, r2;
      logic        rst;
      r1 = $urandom;
      r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
      if (m_mode == 2) halt_run++; else halt_run = 0;
      rst = (halt_run > 3) || ($urandom_range(0, 39) == 0);
      step(rand_iw(), $urandom, r1, r2, 3'($urandom), 15'($urandom_range(0, 32767)) & 15'h739C,
           {$urandom, $urandom, $urandom}, ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), rst);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
